// File: rtl/player_bullet.sv
// Player projectile manager: spawns, moves, draws and retires bullets,
// and flags pixel coincidence with the roaming enemy.
module player_bullet #(
  parameter int          NUM_B     = 4,
  parameter int          B_W       = 2,
  parameter int          B_H       = 6,
  parameter int          TICK_BITS = 17,
  parameter int          SPEED     = 2,
  parameter int          COOLDOWN  = 24,
  parameter int          BOUND_UP  = 31,
  parameter logic [7:0]  B_COLOR   = 8'hFC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
  input  logic       pause,
  input  logic       game_start_on,
  input  logic       game_over_on,
  input  logic [9:0] p_x,
  input  logic [9:0] p_y,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       e_r_on,
  output logic       hit_r_enemy,
  output logic       b_on,
  output logic [7:0] rgb,
  output logic [7:0] shots_fired
);

  localparam int IDX_W = (NUM_B > 1) ? $clog2(NUM_B) : 1;
  localparam int CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [9:0] SPAWN_DX = 10'd7;
  localparam logic [9:0] BW_V     = 10'(B_W);
  localparam logic [9:0] BH_V     = 10'(B_H);
  localparam logic [9:0] STEP_V   = 10'(SPEED);
  localparam logic [9:0] RETIRE_Y = 10'(BOUND_UP + SPEED);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic                 f_s1, f_s2, f_s3;
  logic                 fire_pulse;
  logic [TICK_BITS-1:0] tick_cnt;
  logic                 tick;
  logic [CD_W-1:0]      cd;
  logic [NUM_B-1:0]     act;
  logic [NUM_B-1:0]     hit_q;
  logic [NUM_B-1:0]     free;
  logic [NUM_B-1:0]     cov;
  logic [9:0]           sx [NUM_B];
  logic [9:0]           sy [NUM_B];
  logic [IDX_W-1:0]     sel;
  logic                 free_any;
  logic                 accept;
  logic                 clear;
  logic                 frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_s1 <= 1'b0;
      f_s2 <= 1'b0;
      f_s3 <= 1'b0;
    end else begin
      f_s1 <= fire;
      f_s2 <= f_s1;
      f_s3 <= f_s2;
    end
  end

  assign fire_pulse = f_s2 & ~f_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick_cnt + TICK_BITS'(1);
  end

  assign tick  = &tick_cnt;
  assign clear = game_start_on | game_over_on;
  assign frame = (x == 10'd0) && (y == 10'd0);

  // A retired slot still holding a hit latch is kept out of use until
  // frame start, so a fresh bullet is not killed by a stale latch.
  always_comb begin
    free     = ~act & ~hit_q;
    free_any = |free;
    sel      = '0;
    for (int i = NUM_B - 1; i >= 0; i--)
      if (free[i]) sel = IDX_W'(i);
  end

  assign accept = fire_pulse & ~pause & ~clear
                & (cd == '0) & free_any;

  always_comb begin
    cov = '0;
    for (int i = 0; i < NUM_B; i++)
      cov[i] = act[i]
             && (x >= sx[i]) && (x < sx[i] + BW_V)
             && (y >= sy[i]) && (y < sy[i] + BH_V);
  end

  assign b_on        = |cov;
  assign rgb         = b_on ? B_COLOR : 8'h00;
  assign hit_r_enemy = (b_on & e_r_on) | (|hit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd <= '0;
    end else if (clear) begin
      cd <= '0;
    end else if (accept) begin
      cd <= CD_LOAD;
    end else if (tick && !pause && cd != '0) begin
      cd <= cd - CD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         shots_fired <= 8'd0;
    else if (accept) shots_fired <= shots_fired + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act   <= '0;
      hit_q <= '0;
      for (int i = 0; i < NUM_B; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else if (clear) begin
      act   <= '0;
      hit_q <= '0;
    end else begin
      for (int i = 0; i < NUM_B; i++) begin
        if (frame && hit_q[i]) begin
          act[i] <= 1'b0;
        end else if (accept && sel == IDX_W'(i)) begin
          sx[i]  <= p_x + SPAWN_DX;
          sy[i]  <= p_y - BH_V;
          act[i] <= 1'b1;
        end else if (act[i] && tick && !pause) begin
          if (sy[i] < RETIRE_Y) act[i] <= 1'b0;
          else                  sy[i]  <= sy[i] - STEP_V;
        end
        hit_q[i] <= frame ? 1'b0 : (hit_q[i] | (cov[i] & e_r_on));
      end
    end
  end

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: spawn, cooldown, slot limit,
// movement, retirement, hit latch, pause, clear and reset.
module tb_player_bullet;

  logic       clk;
  logic       rst;
  logic       fire;
  logic       pause;
  logic       game_start_on;
  logic       game_over_on;
  logic [9:0] p_x, p_y, x, y;
  logic       e_r_on;
  logic       hit_r_enemy;
  logic       b_on;
  logic [7:0] rgb;
  logic [7:0] shots_fired;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  player_bullet #(.TICK_BITS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .fire          (fire),
    .pause         (pause),
    .game_start_on (game_start_on),
    .game_over_on  (game_over_on),
    .p_x           (p_x),
    .p_y           (p_y),
    .x             (x),
    .y             (y),
    .e_r_on        (e_r_on),
    .hit_r_enemy   (hit_r_enemy),
    .b_on          (b_on),
    .rgb           (rgb),
    .shots_fired   (shots_fired)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Tick counter runs at 16 clk per tick; ecnt % 16 == 0 marks a tick edge.
  task automatic step();
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      step();
      while (ecnt % 16 != 0) step();
    end
  endtask

  task automatic align();
    while (ecnt % 16 != 0) step();
  endtask

  task automatic shoot(input int px, input int py);
    align();
    p_x  = 10'(px);
    p_y  = 10'(py);
    fire = 1'b1;
    repeat (3) step();
  endtask

  task automatic rel();
    fire = 1'b0;
    repeat (3) step();
  endtask

  task automatic probe(input string tag, input int px, input int py,
                       input logic exp);
    x = 10'(px);
    y = 10'(py);
    #1;
    chk(tag, 32'(b_on), 32'(exp));
  endtask

  task automatic over_pulse();
    game_over_on = 1'b1;
    step();
    game_over_on = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fire = 1'b0; pause = 1'b0;
    game_start_on = 1'b0; game_over_on = 1'b0;
    p_x = 10'd300; p_y = 10'd450;
    x = 10'd700; y = 10'd300; e_r_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bon",   32'(b_on),        32'd0);
    chk("rst_hit",   32'(hit_r_enemy), 32'd0);
    chk("rst_rgb",   32'(rgb),         32'd0);
    chk("rst_shots", 32'(shots_fired), 32'd0);
    rst  = 1'b0;
    ecnt = 0;

    // first shot: loaded on the third clk after the fire edge
    fire = 1'b1;
    step();
    step();
    chk("lat2_shots", 32'(shots_fired), 32'd0);
    step();
    chk("lat3_shots", 32'(shots_fired), 32'd1);
    probe("t1_tl",  307, 444, 1'b1);
    probe("t1_br",  308, 449, 1'b1);
    probe("t1_l",   306, 444, 1'b0);
    probe("t1_r",   309, 444, 1'b0);
    probe("t1_u",   307, 443, 1'b0);
    probe("t1_d",   307, 450, 1'b0);
    x = 10'd308; y = 10'd444; #1;
    chk("t1_rgb_on", 32'(rgb), 32'hFC);
    x = 10'd309; #1;
    chk("t1_rgb_off", 32'(rgb), 32'h00);
    x = 10'd700; y = 10'd300;
    rel();

    wait_ticks(1);
    probe("mv1_top", 307, 442, 1'b1);
    probe("mv1_bot", 307, 447, 1'b1);
    probe("mv1_out", 307, 448, 1'b0);

    // cooldown still running after 10 ticks
    wait_ticks(9);
    shoot(320, 450);
    chk("cd_block", 32'(shots_fired), 32'd1);
    probe("cd_none", 327, 444, 1'b0);
    rel();

    wait_ticks(14);
    shoot(320, 450);
    chk("cd_ok", 32'(shots_fired), 32'd2);
    probe("s2_new", 327, 444, 1'b1);
    probe("s1_at",  307, 396, 1'b1);
    probe("s1_abv", 307, 395, 1'b0);
    rel();

    wait_ticks(24);
    shoot(340, 450);
    chk("s3_cnt", 32'(shots_fired), 32'd3);
    rel();
    wait_ticks(24);
    shoot(360, 450);
    chk("s4_cnt", 32'(shots_fired), 32'd4);
    rel();
    wait_ticks(24);
    shoot(380, 450);
    chk("drop_cnt", 32'(shots_fired), 32'd4);
    probe("drop_none", 387, 444, 1'b0);
    probe("full_a",    307, 252, 1'b1);
    probe("full_b",    327, 300, 1'b1);
    probe("full_c",    347, 348, 1'b1);
    probe("full_d",    367, 396, 1'b1);
    rel();

    over_pulse();
    probe("go_clr_a", 307, 252, 1'b0);
    probe("go_clr_d", 367, 396, 1'b0);
    chk("go_shots", 32'(shots_fired), 32'd4);

    // retirement near the top bound
    shoot(100, 46);
    chk("top_cnt", 32'(shots_fired), 32'd5);
    probe("top_y40", 107, 40, 1'b1);
    probe("top_y39", 107, 39, 1'b0);
    rel();
    wait_ticks(1);
    probe("top_y38", 107, 38, 1'b1);
    probe("top_y43", 107, 43, 1'b1);
    probe("top_y44", 107, 44, 1'b0);
    wait_ticks(2);
    probe("top_y34", 107, 34, 1'b1);
    wait_ticks(1);
    probe("top_y32", 107, 32, 1'b1);
    probe("top_y31", 107, 31, 1'b0);
    wait_ticks(1);
    probe("top_gone",  107, 32, 1'b0);
    probe("top_gone2", 107, 30, 1'b0);

    // hit latch held until frame start, then the slot retires
    over_pulse();
    shoot(200, 450);
    chk("hit_cnt", 32'(shots_fired), 32'd6);
    x = 10'd207; y = 10'd446; e_r_on = 1'b1; #1;
    chk("hit_now", 32'(hit_r_enemy), 32'd1);
    chk("hit_bon", 32'(b_on), 32'd1);
    step();
    x = 10'd600; y = 10'd200; e_r_on = 1'b0; #1;
    chk("hit_hold",  32'(hit_r_enemy), 32'd1);
    chk("hit_bon0",  32'(b_on), 32'd0);
    step();
    chk("hit_hold2", 32'(hit_r_enemy), 32'd1);
    x = 10'd0; y = 10'd0;
    step();
    probe("hit_gone", 207, 444, 1'b0);
    chk("hit_clr", 32'(hit_r_enemy), 32'd0);
    x = 10'd700; y = 10'd300;
    rel();

    // three bullets, pause freezes them, then async reset
    wait_ticks(24);
    shoot(400, 450);
    rel();
    wait_ticks(24);
    shoot(420, 450);
    rel();
    wait_ticks(24);
    shoot(440, 450);
    chk("three_cnt", 32'(shots_fired), 32'd9);
    rel();
    pause = 1'b1;
    wait_ticks(2);
    probe("pz_a",  407, 353, 1'b1);
    probe("pz_b",  427, 396, 1'b1);
    probe("pz_c",  447, 444, 1'b1);
    pause = 1'b0;
    x = 10'd447; y = 10'd446; e_r_on = 1'b1; #1;
    chk("pre_rst_hit", 32'(hit_r_enemy), 32'd1);
    #10;
    rst = 1'b1;
    #1;
    chk("arst_bon",   32'(b_on),        32'd0);
    chk("arst_hit",   32'(hit_r_enemy), 32'd0);
    chk("arst_rgb",   32'(rgb),         32'd0);
    chk("arst_shots", 32'(shots_fired), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
